// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register of the five-stage MIPS core. Captures the decoded
// operands and control bits from ID, turns the slot into a bubble on a
// branch/jump squash or a load-use hazard, and produces the 2-bit selects of
// the two EX operand muxes (register file / EX-MEM / MEM-WB / immediate).
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   id_*                  instruction presented by ID (valid, register numbers,
//                         register-file data, immediate, decoded controls)
//   flush                 squash the instruction currently in ID
//   exm_reg_write/rd_num  destination of the instruction in EX/MEM
//   mwb_reg_write/rd_num  destination of the instruction in MEM/WB
//   ex_*                  registered instruction now in EX
//   fwd_sel_a/b           operand-mux selects: 00 regfile, 01 EX/MEM,
//                         10 MEM/WB, 11 immediate (operand B only)
//   stall_id              hold PC and IF/ID this cycle (load-use)
//   bubble_cnt            saturating count of bubbles that replaced a real
//                         ID instruction
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs_num,
    input  logic [4:0]       id_rt_num,
    input  logic [4:0]       id_rd_num,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_alu_src,
    input  logic             flush,
    input  logic             exm_reg_write,
    input  logic [4:0]       exm_rd_num,
    input  logic             mwb_reg_write,
    input  logic [4:0]       mwb_rd_num,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_alu_src,
    output logic [4:0]       ex_rs_num,
    output logic [4:0]       ex_rt_num,
    output logic [4:0]       ex_rd_num,
    output logic [WIDTH-1:0] ex_rs_data,
    output logic [WIDTH-1:0] ex_rt_data,
    output logic [WIDTH-1:0] ex_imm,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             stall_id,
    output logic [15:0]      bubble_cnt
);

    logic             valid_q, valid_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             alu_src_q, alu_src_d;
    logic [4:0]       rs_num_q, rs_num_d;
    logic [4:0]       rt_num_q, rt_num_d;
    logic [4:0]       rd_num_q, rd_num_d;
    logic [WIDTH-1:0] rs_data_q, rs_data_d;
    logic [WIDTH-1:0] rt_data_q, rt_data_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             load_bubble;

    // Forwarding source for one operand; EX/MEM is younger so it wins,
    // and $0 is hardwired so it is never forwarded.
    function automatic logic [1:0] fwd_src(input logic [4:0] num,
                                           input logic       exm_we,
                                           input logic [4:0] exm_rd,
                                           input logic       mwb_we,
                                           input logic [4:0] mwb_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (exm_we && (exm_rd != 5'd0) && (exm_rd == num)) begin
            sel = 2'b01;
        end else if (mwb_we && (mwb_rd != 5'd0) && (mwb_rd == num)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // A load in EX whose result ID needs cannot be forwarded in time.
    always_comb begin
        stall_id = valid_q & mem_read_q & (rd_num_q != 5'd0) & id_valid &
                   ((rd_num_q == id_rs_num) | (rd_num_q == id_rt_num));
    end

    assign load_bubble = flush | stall_id;

    always_comb begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        alu_src_d   = 1'b0;
        rs_num_d    = 5'd0;
        rt_num_d    = 5'd0;
        rd_num_d    = 5'd0;
        rs_data_d   = '0;
        rt_data_d   = '0;
        imm_d       = '0;
        if (!load_bubble) begin
            valid_d     = id_valid;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            alu_src_d   = id_alu_src;
            rs_num_d    = id_rs_num;
            rt_num_d    = id_rt_num;
            rd_num_d    = id_rd_num;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = id_imm;
        end
    end

    // Only bubbles that displaced a real instruction are counted.
    always_comb begin
        cnt_d = cnt_q;
        if (load_bubble && id_valid && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            alu_src_q   <= 1'b0;
            rs_num_q    <= 5'd0;
            rt_num_q    <= 5'd0;
            rd_num_q    <= 5'd0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            cnt_q       <= 16'd0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            alu_src_q   <= alu_src_d;
            rs_num_q    <= rs_num_d;
            rt_num_q    <= rt_num_d;
            rd_num_q    <= rd_num_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        fwd_sel_a = fwd_src(rs_num_q, exm_reg_write, exm_rd_num,
                            mwb_reg_write, mwb_rd_num);
        if (alu_src_q) begin
            fwd_sel_b = 2'b11;
        end else begin
            fwd_sel_b = fwd_src(rt_num_q, exm_reg_write, exm_rd_num,
                                mwb_reg_write, mwb_rd_num);
        end
    end

    assign ex_valid     = valid_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_alu_src   = alu_src_q;
    assign ex_rs_num    = rs_num_q;
    assign ex_rt_num    = rt_num_q;
    assign ex_rd_num    = rd_num_q;
    assign ex_rs_data   = rs_data_q;
    assign ex_rt_data   = rt_data_q;
    assign ex_imm       = imm_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage MIPS core. It latches decoded operands and control bits from ID, inserts bubbles on flush or load-use hazard, and drives the 2-bit `select` inputs of the two `Mux_2` operand muxes in EX. Those muxes choose between the register file, EX/MEM forwarding, MEM/WB forwarding and the immediate. It sits between the decoder/register file upstream and the forwarding muxes/ALU downstream.

## Interface
- `WIDTH`, 32, datapath width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_rs_num`, `id_rt_num`, `id_rd_num`  in  5  source/destination register numbers (`rd` already resolved rt/rd/31)
- `id_rs_data`, `id_rt_data`  in  WIDTH  register-file read data
- `id_imm`  in  WIDTH  extended immediate
- `id_reg_write`, `id_mem_read`, `id_alu_src`  in  1  decoded controls
- `flush`  in  1  branch/jump squash of the instruction in ID
- `exm_reg_write`  in  1  EX/MEM write enable
- `exm_rd_num`  in  5  EX/MEM destination
- `mwb_reg_write`  in  1  MEM/WB write enable
- `mwb_rd_num`  in  5  MEM/WB destination
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_alu_src`  out  1  registered controls
- `ex_rs_num`, `ex_rt_num`, `ex_rd_num`  out  5  registered register numbers
- `ex_rs_data`, `ex_rt_data`, `ex_imm`  out  WIDTH  registered operands
- `fwd_sel_a`, `fwd_sel_b`  out  2  operand-mux selects
- `stall_id`  out  1  hold PC and IF/ID this cycle
- `bubble_cnt`  out  16  saturating count of inserted bubbles

## Operation
- **Load-use hazard (combinational):**
  - `stall_id` = `ex_valid & ex_mem_read & (ex_rd_num != 0) & id_valid & (ex_rd_num == id_rs_num | ex_rd_num == id_rt_num)`.
- **Register update, each rising edge, in priority order:**
  - `flush` = 1 loads a bubble.
  - Otherwise, `stall_id` = 1 loads a bubble.
  - Otherwise, all ID inputs are captured; `ex_valid` = `id_valid`.
- **Bubble contents:**
  - `ex_valid`, `ex_reg_write`, `ex_mem_read` and `ex_alu_src` = 0.
  - Data and number fields = 0.
- **`bubble_cnt`:**
  - Increments on every edge that loads a bubble because of `flush` or `stall_id` with `id_valid` = 1.
  - Saturates at 16'hFFFF and does not wrap.
- **`fwd_sel_a` (combinational, from registered EX fields):**
  - 2'b01 if `exm_reg_write` and `exm_rd_num != 0` and `exm_rd_num == ex_rs_num`.
  - Else 2'b10 if `mwb_reg_write` and `mwb_rd_num != 0` and `mwb_rd_num == ex_rs_num`.
  - Else 2'b00.
  - Never 2'b11.
- **`fwd_sel_b`:**
  - 2'b11 (immediate, mux `Data_3`) when `ex_alu_src` = 1.
  - Otherwise the same rule as `fwd_sel_a`, using `ex_rt_num`.
- **Forwarding priority:** EX/MEM always wins over MEM/WB when both match.
- **Register 0:** never forwarded.
- **Bubble in EX:** with `ex_valid` = 0, selects are still computed. This is harmless because the bubble's writes are disabled.

## Timing
- **Reset:** `rst_n` low clears all registered outputs to 0 immediately, without waiting for a clock edge.
  - Resulting values: `fwd_sel_a` = `fwd_sel_b` = 2'b00, `stall_id` = 0, `bubble_cnt` = 0.
  - Reset assertion mid-stall discards the held instruction.
  - First capture is at the first rising edge after deassertion.
- **Latency:**
  - ID to EX outputs: 1 cycle.
  - Selects and `stall_id`: same cycle as their inputs (no added latency).
- **Load-use stall length:** exactly 1 cycle. Once the load advances to MEM, `stall_id` drops and MEM/WB forwarding (2'b10) covers the dependency on the following cycle.
- **`flush` and `stall_id` together:** a single bubble is loaded, and `bubble_cnt` increments once.
- **Counter at saturation:** further bubbles leave `bubble_cnt` at 16'hFFFF.

## Test plan
- **Reset:** drive all inputs nonzero, pulse `rst_n` low mid-cycle -> all outputs read 0 before the next edge, `bubble_cnt` = 0.
- **EX/MEM forward:** `ex_rs_num` = 8 with `exm_reg_write` = 1, `exm_rd_num` = 8, and `mwb_rd_num` = 8 with `mwb_reg_write` = 1 -> `fwd_sel_a` = 2'b01. Change `exm_rd_num` to 9 -> `fwd_sel_a` = 2'b10. Set both numbers to 0 -> 2'b00.
- **Immediate select:** `ex_alu_src` = 1 with an EX/MEM match on `ex_rt_num` -> `fwd_sel_b` = 2'b11.
- **Load-use:** EX holds `lw`, `ex_rd_num` = 4; ID has `id_rt_num` = 4 -> `stall_id` = 1 for one cycle, next edge `ex_valid` = 0, `bubble_cnt` = 1; following cycle `stall_id` = 0 and the instruction is captured.
- **Flush + stall:** `flush` = 1 together with a load-use hazard -> single bubble, `bubble_cnt` +1. Also a `lw` to `$0` with a matching ID source -> `stall_id` = 0.
- **Saturation:** preload 65534 bubbles, insert 3 more -> `bubble_cnt` = 16'hFFFF and holds.
